// File: rtl/knn_topk.sv
// knn_topk: streaming k-nearest-neighbour engine with a sorted top-K list and a 2-stage distance pipeline.
// Define KNN_VOTE_EN to add the one-cycle majority-vote state and the vote_label result.
module knn_topk #(
    parameter int COORD_W = 16,
    parameter int K       = 4,
    parameter int LABEL_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic [COORD_W-1:0]           test_x,
    input  logic [COORD_W-1:0]           test_y,
    input  logic                         pt_valid,
    output logic                         pt_ready,
    input  logic [COORD_W-1:0]           pt_x,
    input  logic [COORD_W-1:0]           pt_y,
    input  logic [LABEL_W-1:0]           pt_label,
    input  logic                         pt_last,
    output logic                         busy,
    output logic                         done,
    output logic [K*(2*COORD_W+1)-1:0]   nn_dist,
    output logic [K*LABEL_W-1:0]         nn_label,
    output logic [$clog2(K+1)-1:0]       nn_count,
    output logic [LABEL_W-1:0]           vote_label
);
    localparam int DIST_W = 2*COORD_W+1;
    localparam int CNT_W  = $clog2(K+1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
`ifdef KNN_VOTE_EN
    localparam logic [2:0] ST_VOTE  = 3'd3;
`endif
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [2:0]         state_q, state_d;
    logic [COORD_W-1:0] tx_q, tx_d, ty_q, ty_d;
    logic               s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [COORD_W-1:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
    logic [LABEL_W-1:0] s1_label_q, s1_label_d;
    logic               s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [DIST_W-1:0]  s2_dist_q, s2_dist_d;
    logic [LABEL_W-1:0] s2_label_q, s2_label_d;
    logic [DIST_W-1:0]  dist_q [K];
    logic [DIST_W-1:0]  dist_d [K];
    logic [LABEL_W-1:0] label_q [K];
    logic [LABEL_W-1:0] label_d [K];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               last_ins_q, last_ins_d;

    logic               accept_s;
    logic [K-1:0]       cond_s, first_s;
    logic [DIST_W-1:0]  prev_dist_s [K];
    logic [LABEL_W-1:0] prev_label_s [K];

    assign pt_ready = en & (state_q == ST_RUN);
    assign accept_s = pt_valid & pt_ready;
    assign busy     = (state_q != ST_IDLE);
    assign done     = en & (state_q == ST_DONE);
    assign nn_count = count_q;

    for (genvar g = 0; g < K; g++) begin : g_list
        assign nn_dist[g*DIST_W +: DIST_W]   = dist_q[g];
        assign nn_label[g*LABEL_W +: LABEL_W] = label_q[g];
        if (g == 0) begin : g_head
            assign prev_dist_s[g]  = {DIST_W{1'b0}};
            assign prev_label_s[g] = {LABEL_W{1'b0}};
        end else begin : g_tail
            assign prev_dist_s[g]  = dist_q[g-1];
            assign prev_label_s[g] = label_q[g-1];
        end
    end

    // The list is sorted with invalid entries last, so cond_s is monotone and first_s marks the insert slot.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            cond_s[i] = (CNT_W'(i) >= count_q) | (s2_dist_q < dist_q[i]);
        end
        first_s = cond_s & ~(cond_s << 1);
    end

`ifdef KNN_VOTE_EN
    logic [CNT_W-1:0]   vote_cnt_s [K];
    logic [CNT_W-1:0]   vote_best_s;
    logic [LABEL_W-1:0] vote_s, vote_q, vote_d;

    // Majority label over valid entries; strict compare keeps the nearest entry on a tie.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            vote_cnt_s[i] = {CNT_W{1'b0}};
            for (int j = 0; j < K; j++) begin
                vote_cnt_s[i] = vote_cnt_s[i] +
                    (((CNT_W'(j) < count_q) && (label_q[j] == label_q[i])) ? CNT_W'(1) : CNT_W'(0));
            end
        end
        vote_best_s = {CNT_W{1'b0}};
        vote_s      = {LABEL_W{1'b0}};
        for (int i = 0; i < K; i++) begin
            if ((CNT_W'(i) < count_q) && (vote_cnt_s[i] > vote_best_s)) begin
                vote_best_s = vote_cnt_s[i];
                vote_s      = label_q[i];
            end else begin
                vote_best_s = vote_best_s;
                vote_s      = vote_s;
            end
        end
    end
    assign vote_label = vote_q;
`else
    assign vote_label = {LABEL_W{1'b0}};
`endif

    // Next-state logic for FSM, pipeline and list; en low holds everything.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        s1_valid_d = s1_valid_q;
        s1_dx_d    = s1_dx_q;
        s1_dy_d    = s1_dy_q;
        s1_label_d = s1_label_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_dist_d  = s2_dist_q;
        s2_label_d = s2_label_q;
        s2_last_d  = s2_last_q;
        dist_d     = dist_q;
        label_d    = label_q;
        count_d    = count_q;
        last_ins_d = last_ins_q;
`ifdef KNN_VOTE_EN
        vote_d     = vote_q;
`endif
        if (en) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_dx_d    = abs_diff(pt_x, tx_q);
                s1_dy_d    = abs_diff(pt_y, ty_q);
                s1_label_d = pt_label;
                s1_last_d  = pt_last;
            end else begin
                s1_last_d  = 1'b0;
            end
            s2_valid_d = s1_valid_q;
            s2_dist_d  = DIST_W'(s1_dx_q) * DIST_W'(s1_dx_q) + DIST_W'(s1_dy_q) * DIST_W'(s1_dy_q);
            s2_label_d = s1_label_q;
            s2_last_d  = s1_last_q;
            if (s2_valid_q) begin
                for (int i = 0; i < K; i++) begin
                    dist_d[i]  = first_s[i] ? s2_dist_q  : (cond_s[i] ? prev_dist_s[i]  : dist_q[i]);
                    label_d[i] = first_s[i] ? s2_label_q : (cond_s[i] ? prev_label_s[i] : label_q[i]);
                end
                count_d    = (cond_s[K-1] && (count_q < CNT_W'(K))) ? (count_q + CNT_W'(1)) : count_q;
                last_ins_d = s2_last_q | last_ins_q;
            end else begin
                last_ins_d = last_ins_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_RUN;
                        tx_d       = test_x;
                        ty_d       = test_y;
                        count_d    = {CNT_W{1'b0}};
                        last_ins_d = 1'b0;
                        for (int i = 0; i < K; i++) begin
                            dist_d[i]  = {DIST_W{1'b0}};
                            label_d[i] = {LABEL_W{1'b0}};
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    state_d = (accept_s && pt_last) ? ST_DRAIN : ST_RUN;
                end
                ST_DRAIN: begin
                    if (last_ins_q) begin
                        last_ins_d = 1'b0;
`ifdef KNN_VOTE_EN
                        state_d    = ST_VOTE;
`else
                        state_d    = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
`ifdef KNN_VOTE_EN
                ST_VOTE: begin
                    vote_d  = vote_s;
                    state_d = ST_DONE;
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= {COORD_W{1'b0}};
            ty_q       <= {COORD_W{1'b0}};
            s1_valid_q <= 1'b0;
            s1_dx_q    <= {COORD_W{1'b0}};
            s1_dy_q    <= {COORD_W{1'b0}};
            s1_label_q <= {LABEL_W{1'b0}};
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_dist_q  <= {DIST_W{1'b0}};
            s2_label_q <= {LABEL_W{1'b0}};
            s2_last_q  <= 1'b0;
            count_q    <= {CNT_W{1'b0}};
            last_ins_q <= 1'b0;
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= {DIST_W{1'b0}};
                label_q[i] <= {LABEL_W{1'b0}};
            end
`ifdef KNN_VOTE_EN
            vote_q     <= {LABEL_W{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            s1_valid_q <= s1_valid_d;
            s1_dx_q    <= s1_dx_d;
            s1_dy_q    <= s1_dy_d;
            s1_label_q <= s1_label_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_dist_q  <= s2_dist_d;
            s2_label_q <= s2_label_d;
            s2_last_q  <= s2_last_d;
            count_q    <= count_d;
            last_ins_q <= last_ins_d;
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= dist_d[i];
                label_q[i] <= label_d[i];
            end
`ifdef KNN_VOTE_EN
            vote_q     <= vote_d;
`endif
        end
    end
endmodule

// File: tb/tb_knn_topk.sv
// tb_knn_topk: directed-vector bench for knn_topk with hand-computed expected lists and timing.
module tb_knn_topk;
    localparam int DW = 33;
    localparam int LW = 4;
`ifdef KNN_VOTE_EN
    localparam int VL = 1;
`else
    localparam int VL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   test_x = 16'd0, test_y = 16'd0;
    logic          pt_valid = 1'b0;
    logic          pt_ready;
    logic [15:0]   pt_x = 16'd0, pt_y = 16'd0;
    logic [3:0]    pt_label = 4'd0;
    logic          pt_last = 1'b0;
    logic          busy, done;
    logic [131:0]  nn_dist;
    logic [15:0]   nn_label;
    logic [2:0]    nn_count;
    logic [3:0]    vote_label;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int start_cyc, last_cyc, done_cyc;
    int px [8];
    int py [8];
    int pl [8];
    longint exp_d [4];
    int exp_l [4];

    knn_topk dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .test_x(test_x), .test_y(test_y),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_label(pt_label), .pt_last(pt_last),
        .busy(busy), .done(done),
        .nn_dist(nn_dist), .nn_label(nn_label), .nn_count(nn_count),
        .vote_label(vote_label)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_pt(input int i, input int x, input int y, input int l);
        px[i] = x; py[i] = y; pl[i] = l;
    endtask

    task automatic do_start(input int tx, input int ty);
        start = 1'b1; test_x = 16'(tx); test_y = 16'(ty);
        tick();
        start_cyc = cyc;
        start = 1'b0;
        check("ready_after_start", {63'd0, pt_ready}, 64'd1);
    endtask

    // Streams n table points; en held low 5 cycles before point stall_idx, valid dropped 2 cycles before gap_idx.
    task automatic run_stream(input int n, input int stall_idx, input int gap_idx);
        int idx = 0, stalls = 0, gaps = 0, guard = 0;
        logic acc;
        while (idx < n && guard < 200) begin
            en = 1'b1; pt_valid = 1'b1;
            if (idx == stall_idx && stalls < 5) begin
                en = 1'b0; stalls++;
            end else if (idx == gap_idx && gaps < 2) begin
                pt_valid = 1'b0; gaps++;
            end
            pt_x = 16'(px[idx]); pt_y = 16'(py[idx]); pt_label = 4'(pl[idx]);
            pt_last = (idx == n-1);
            #1;
            if (!en) check("ready_low_when_stalled", {63'd0, pt_ready}, 64'd0);
            acc = pt_valid & pt_ready;
            tick();
            if (acc) begin
                if (idx == n-1) last_cyc = cyc;
                idx++;
            end
            guard++;
        end
        pt_valid = 1'b0; pt_last = 1'b0; en = 1'b1;
        check("stream_accepts", 64'(idx), 64'(n));
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 40) begin
            tick();
            g++;
        end
        done_cyc = cyc;
        check("done_seen", {63'd0, done}, 64'd1);
        tick();
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_list(input string tag, input int cnt);
        check({tag, "_count"}, 64'(nn_count), 64'(cnt));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_dist%0d", tag, i), 64'(nn_dist[i*DW +: DW]), exp_d[i]);
            check($sformatf("%s_label%0d", tag, i), 64'(nn_label[i*LW +: LW]), 64'(exp_l[i]));
        end
    endtask

    task automatic single_point(input string tag);
        do_start(1, 8);
        set_pt(0, 4, 3, 2);
        run_stream(1, -1, -1);
        wait_done();
        check({tag, "_latency"}, 64'(done_cyc - last_cyc), 64'(3 + VL));
        exp_d = '{34, 0, 0, 0}; exp_l = '{2, 0, 0, 0};
        check_list(tag, 1);
    endtask

    task automatic load_sort_stream();
        set_pt(0, 3, 4, 1); set_pt(1, 1, 1, 2); set_pt(2, 10, 0, 3);
        set_pt(3, 0, 2, 4); set_pt(4, 5, 5, 5); set_pt(5, 0, 0, 6);
    endtask

    initial begin
        tick(); tick();
        check("rst_ready", {63'd0, pt_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dist", {63'd0, |nn_dist}, 64'd0);
        check("rst_label", {63'd0, |nn_label}, 64'd0);
        check("rst_count", 64'(nn_count), 64'd0);
        check("rst_vote", 64'(vote_label), 64'd0);
        rst = 1'b0;
        tick();

        single_point("single");

        load_sort_stream();
        do_start(0, 0);
        run_stream(6, -1, -1);
        wait_done();
        check("sort_start_to_done", 64'(done_cyc - start_cyc), 64'(9 + VL));
        exp_d = '{0, 2, 4, 25}; exp_l = '{6, 2, 4, 1};
        check_list("sort", 4);
        check("sort_vote", 64'(vote_label), (VL == 1) ? 64'd6 : 64'd0);

        load_sort_stream();
        do_start(0, 0);
        run_stream(6, 2, 4);
        wait_done();
        check("stall_start_to_done", 64'(done_cyc - start_cyc), 64'(16 + VL));
        check_list("stall", 4);

        set_pt(0, 1, 0, 1); set_pt(1, 0, 1, 2);
        do_start(0, 0);
        run_stream(2, -1, -1);
        wait_done();
        exp_d = '{1, 1, 0, 0}; exp_l = '{1, 2, 0, 0};
        check_list("tie", 2);

        set_pt(0, 65535, 65535, 7);
        do_start(0, 0);
        run_stream(1, -1, -1);
        wait_done();
        exp_d = '{64'd8589672450, 0, 0, 0}; exp_l = '{7, 0, 0, 0};
        check_list("maxrange", 1);

        set_pt(0, 1, 0, 3); set_pt(1, 1, 1, 5); set_pt(2, 0, 2, 5); set_pt(3, 0, 3, 3);
        do_start(0, 0);
        run_stream(4, -1, -1);
        wait_done();
        exp_d = '{1, 2, 4, 9}; exp_l = '{3, 5, 5, 3};
        check_list("vote4", 4);
        check("vote4_label", 64'(vote_label), (VL == 1) ? 64'd3 : 64'd0);

        do_start(0, 0);
        run_stream(3, -1, -1);
        wait_done();
        exp_d = '{1, 2, 4, 0}; exp_l = '{3, 5, 5, 0};
        check_list("vote3", 3);
        check("vote3_label", 64'(vote_label), (VL == 1) ? 64'd5 : 64'd0);

        do_start(0, 0);
        pt_valid = 1'b1; pt_x = 16'd3; pt_y = 16'd4; pt_label = 4'd1; pt_last = 1'b0;
        tick(); tick(); tick(); tick();
        check("midq_count_before_rst", 64'(nn_count), 64'd2);
        rst = 1'b1;
        tick();
        pt_valid = 1'b0;
        check("midq_rst_ready", {63'd0, pt_ready}, 64'd0);
        check("midq_rst_busy", {63'd0, busy}, 64'd0);
        check("midq_rst_done", {63'd0, done}, 64'd0);
        check("midq_rst_dist", {63'd0, |nn_dist}, 64'd0);
        check("midq_rst_label", {63'd0, |nn_label}, 64'd0);
        check("midq_rst_count", 64'(nn_count), 64'd0);
        check("midq_rst_vote", 64'(vote_label), 64'd0);
        rst = 1'b0;
        tick();
        single_point("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
